// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the register-read stage, the issue stage and the ALU.
// The slave modport is the issue stage's view. The master modport is the surrounding pipeline's view.
interface alu_issue_stage_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic             add_en;
    logic             sub_en;
    logic             sra_en;
    logic             sll_en;
    logic             slt_en;
    logic             sltu_en;
    logic             xor_en;
    logic             srl_en;
    logic             or_en;
    logic             and_en;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [4:0]       rd_addr;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid,
        output add_en, sub_en, sra_en, sll_en, slt_en, sltu_en,
        output xor_en, srl_en, or_en, and_en,
        output op_a, op_b, rd_addr, illegal, illegal_count
    );

    modport master (
        output in_valid, instr, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid,
        input  add_en, sub_en, sra_en, sll_en, slt_en, sltu_en,
        input  xor_en, srl_en, or_en, and_en,
        input  op_a, op_b, rd_addr, illegal, illegal_count
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode and issue register: one-hot ALU strobes plus operands, valid/ready out.
// Valid/ready: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module alu_issue_stage #(
    parameter int IMM_W = 12,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);
    // Bit positions of the one-hot enable vector
    localparam int B_ADD  = 0;
    localparam int B_SUB  = 1;
    localparam int B_SRA  = 2;
    localparam int B_SLL  = 3;
    localparam int B_SLT  = 4;
    localparam int B_SLTU = 5;
    localparam int B_XOR  = 6;
    localparam int B_SRL  = 7;
    localparam int B_OR   = 8;
    localparam int B_AND  = 9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       en_q, en_d;
    logic             ill_q, ill_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic [4:0]       rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_sext;
    logic [9:0]  dec_en;
    logic        dec_ill;
    logic [31:0] dec_opb;
    logic        accept;
    logic        drain;
    logic        unused_rs1_field;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign funct7   = bus.instr[31:25];
    assign imm_sext = {{(32-IMM_W){bus.instr[19+IMM_W]}}, bus.instr[19+IMM_W:20]};
    assign unused_rs1_field = ^bus.instr[19:15];

    function automatic logic [9:0] f3_onehot(input logic [2:0] f3);
        logic [9:0] e;
        e = '0;
        case (f3)
            3'b000:  e[B_ADD]  = 1'b1;
            3'b001:  e[B_SLL]  = 1'b1;
            3'b010:  e[B_SLT]  = 1'b1;
            3'b011:  e[B_SLTU] = 1'b1;
            3'b100:  e[B_XOR]  = 1'b1;
            3'b101:  e[B_SRL]  = 1'b1;
            3'b110:  e[B_OR]   = 1'b1;
            default: e[B_AND]  = 1'b1;
        endcase
        return e;
    endfunction

    always_comb begin
        dec_en  = '0;
        dec_ill = 1'b0;
        dec_opb = bus.rs2_data;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO) begin
                    dec_en = f3_onehot(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_en[B_SUB] = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_en[B_SRA] = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Shift-immediates reuse the upper immediate bits as a funct7 qualifier
                dec_opb = imm_sext;
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_ZERO) dec_en[B_SLL] = 1'b1;
                    else                   dec_ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ZERO)     dec_en[B_SRL] = 1'b1;
                    else if (funct7 == F7_ALT) dec_en[B_SRA] = 1'b1;
                    else                       dec_ill = 1'b1;
                end else begin
                    dec_en = f3_onehot(funct3);
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign drain        = (state_q == FULL) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        if (flush)       state_d = EMPTY;
        else if (accept) state_d = FULL;
        else if (drain)  state_d = EMPTY;
    end

    always_comb begin
        en_d  = en_q;
        ill_d = ill_q;
        opa_d = opa_q;
        opb_d = opb_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            en_d  = '0;
            ill_d = 1'b0;
        end else if (accept) begin
            en_d  = dec_en;
            ill_d = dec_ill;
            opa_d = bus.rs1_data;
            opb_d = dec_opb;
            rd_d  = bus.instr[11:7];
            if (dec_ill && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else if (drain) begin
            en_d  = '0;
            ill_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            en_q    <= '0;
            ill_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ill_q   <= ill_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid     = (state_q == FULL);
    assign bus.add_en        = en_q[B_ADD];
    assign bus.sub_en        = en_q[B_SUB];
    assign bus.sra_en        = en_q[B_SRA];
    assign bus.sll_en        = en_q[B_SLL];
    assign bus.slt_en        = en_q[B_SLT];
    assign bus.sltu_en       = en_q[B_SLTU];
    assign bus.xor_en        = en_q[B_XOR];
    assign bus.srl_en        = en_q[B_SRL];
    assign bus.or_en         = en_q[B_OR];
    assign bus.and_en        = en_q[B_AND];
    assign bus.op_a          = opa_q;
    assign bus.op_b          = opb_q;
    assign bus.rd_addr       = rd_q;
    assign bus.illegal       = ill_q;
    assign bus.illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a decode vector table streamed back-to-back, plus hold, flush,
// saturation and mid-cycle reset sequences. The counter is built 4 bits wide so saturation is reachable.
module tb_alu_issue_stage;
    localparam int CNT_W = 4;

    localparam logic [9:0] E_NONE = 10'h000;
    localparam logic [9:0] E_ADD  = 10'h001;
    localparam logic [9:0] E_SUB  = 10'h002;
    localparam logic [9:0] E_SRA  = 10'h004;
    localparam logic [9:0] E_SLL  = 10'h008;
    localparam logic [9:0] E_SLT  = 10'h010;
    localparam logic [9:0] E_SLTU = 10'h020;
    localparam logic [9:0] E_XOR  = 10'h040;
    localparam logic [9:0] E_SRL  = 10'h080;
    localparam logic [9:0] E_OR   = 10'h100;
    localparam logic [9:0] E_AND  = 10'h200;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  en;
        logic        use_rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;
    int   exp_cnt;

    alu_issue_stage_if #(.CNT_W(CNT_W)) bus ();

    alu_issue_stage #(.IMM_W(12), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] en_vec();
        return {bus.and_en, bus.or_en, bus.srl_en, bus.xor_en, bus.sltu_en,
                bus.slt_en, bus.sll_en, bus.sra_en, bus.sub_en, bus.add_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    task automatic chk_entry(input string tag, input logic [9:0] en, input logic [31:0] opa,
                             input logic [31:0] opb, input logic [4:0] rd, input logic ill);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".en"}, 32'(en_vec()), 32'(en));
        chk({tag, ".op_a"}, bus.op_a, opa);
        chk({tag, ".op_b"}, bus.op_b, opb);
        chk({tag, ".rd"}, 32'(bus.rd_addr), 32'(rd));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".en"}, 32'(en_vec()), 32'd0);
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    task automatic bump_cnt();
        if (exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
    endtask

    vec_t vt[21];

    initial begin
        vt[0]  = '{32'h002081B3, E_ADD,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[1]  = '{32'h402081B3, E_SUB,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[2]  = '{32'h4030D293, E_SRA,  1'b0, 32'h00000403, 5'd5, 1'b0};
        vt[3]  = '{32'hFFF00293, E_ADD,  1'b0, 32'hFFFFFFFF, 5'd5, 1'b0};
        vt[4]  = '{32'h002091B3, E_SLL,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[5]  = '{32'h0020A1B3, E_SLT,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[6]  = '{32'h0020B1B3, E_SLTU, 1'b1, 32'h0,        5'd3, 1'b0};
        vt[7]  = '{32'h0020C1B3, E_XOR,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[8]  = '{32'h0020D1B3, E_SRL,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[9]  = '{32'h0020E1B3, E_OR,   1'b1, 32'h0,        5'd3, 1'b0};
        vt[10] = '{32'h0020F1B3, E_AND,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[11] = '{32'h4020D1B3, E_SRA,  1'b1, 32'h0,        5'd3, 1'b0};
        vt[12] = '{32'hFFE0A293, E_SLT,  1'b0, 32'hFFFFFFFE, 5'd5, 1'b0};
        vt[13] = '{32'h7FF0F293, E_AND,  1'b0, 32'h000007FF, 5'd5, 1'b0};
        vt[14] = '{32'h00409293, E_SLL,  1'b0, 32'h00000004, 5'd5, 1'b0};
        vt[15] = '{32'h01F0D293, E_SRL,  1'b0, 32'h0000001F, 5'd5, 1'b0};
        vt[16] = '{32'h402091B3, E_NONE, 1'b1, 32'h0,        5'd3, 1'b1};
        vt[17] = '{32'h0000006F, E_NONE, 1'b1, 32'h0,        5'd0, 1'b1};
        vt[18] = '{32'h40409293, E_NONE, 1'b0, 32'h00000404, 5'd5, 1'b1};
        vt[19] = '{32'h022081B3, E_NONE, 1'b1, 32'h0,        5'd3, 1'b1};
        vt[20] = '{32'h0230D293, E_NONE, 1'b0, 32'h00000023, 5'd5, 1'b1};

        checks = 0;
        errors = 0;
        exp_cnt = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_empty("reset");
        chk("reset.op_a", bus.op_a, 32'd0);
        chk("reset.op_b", bus.op_b, 32'd0);
        chk("reset.rd", 32'(bus.rd_addr), 32'd0);
        chk("reset.count", 32'(bus.illegal_count), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Table vectors streamed back-to-back: each negedge checks entry i and offers entry i+1
        @(negedge clk);
        drive(vt[0].instr, 32'h1000_0000, 32'h8000_0000);
        for (int i = 0; i < 21; i++) begin
            logic [31:0] r1, r2, eb;
            r1 = 32'h1000_0000 | 32'(i);
            r2 = 32'h8000_0000 | (32'(i) << 4);
            eb = vt[i].use_rs2 ? r2 : vt[i].imm;
            if (vt[i].ill) bump_cnt();
            @(negedge clk);
            chk_entry($sformatf("vec%0d", i), vt[i].en, r1, eb, vt[i].rd, vt[i].ill);
            chk($sformatf("vec%0d.count", i), 32'(bus.illegal_count), 32'(exp_cnt));
            if (i < 20) drive(vt[i+1].instr, 32'h1000_0000 | 32'(i + 1),
                              32'h8000_0000 | (32'(i + 1) << 4));
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk_empty("drain");

        // Hold: addi x5,x0,-1 stalled for 3 cycles while a second instruction waits
        bus.out_ready = 1'b0;
        drive(32'hFFF00293, 32'd0, 32'h1234);
        @(negedge clk);
        drive(32'h002081B3, 32'd5, 32'd7);
        for (int k = 0; k < 3; k++) begin
            chk_entry($sformatf("hold%0d", k), E_ADD, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b0);
            chk($sformatf("hold%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("hold.in_ready_release", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk_entry("hold.next", E_ADD, 32'd5, 32'd7, 5'd3, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_empty("hold.drain");

        // Flush beats a simultaneous offer; the offer is taken the next cycle instead
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h11, 32'h22);
        @(negedge clk);
        chk_entry("flush.pre", E_ADD, 32'h11, 32'h22, 5'd3, 1'b0);
        drive(32'h0000006F, 32'h33, 32'h44);
        flush = 1'b1;
        @(negedge clk);
        chk_empty("flush");
        chk("flush.count", 32'(bus.illegal_count), 32'(exp_cnt));
        flush = 1'b0;
        @(negedge clk);
        bump_cnt();
        chk_entry("flush.after", E_NONE, 32'h33, 32'h44, 5'd0, 1'b1);
        chk("flush.after.count", 32'(bus.illegal_count), 32'(exp_cnt));
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_empty("flush.drain");

        // Saturation: stream illegal instructions well past all-ones
        for (int k = 0; k < 12; k++) begin
            drive(32'h402091B3, 32'(k), 32'(k));
            @(negedge clk);
            bump_cnt();
            chk($sformatf("sat%0d.count", k), 32'(bus.illegal_count), 32'(exp_cnt));
        end
        chk("sat.final", 32'(bus.illegal_count), 32'h0000000F);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset pulsed between edges while an entry is held
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h55, 32'h66);
        @(negedge clk);
        chk_entry("rst.pre", E_ADD, 32'h55, 32'h66, 5'd3, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_empty("rst.async");
        chk("rst.op_a", bus.op_a, 32'd0);
        chk("rst.op_b", bus.op_b, 32'd0);
        chk("rst.rd", 32'(bus.rd_addr), 32'd0);
        chk("rst.count", 32'(bus.illegal_count), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_empty("rst.post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that drives the ALU result multiplexer. It accepts one 32-bit RV32I OP / OP-IMM instruction per handshake together with its register-file operands, and decodes funct3/funct7 into the one-hot `*_en` strobes consumed by the ALU. It launches the enables plus the selected operands from an output register under a valid/ready handshake. It sits between the register-file read stage and the ALU. It also flags unsupported encodings and counts them.

## Interface
- `IMM_W`, 12: I-type immediate width; sign-extended to 32 bits for `op_b`.
- `CNT_W`, 16: width of the saturating illegal-instruction counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush`  in  1  synchronous; discards any held entry.
- `in_valid`  in  1  upstream holds valid instruction/operands.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  instruction word.
- `rs1_data`  in  32  register-file value of rs1.
- `rs2_data`  in  32  register-file value of rs2 (ignored for OP-IMM).
- `out_valid`  out  1  output register holds an entry.
- `out_ready`  in  1  ALU/writeback accepts entry.
- `add_en, sub_en, sra_en, sll_en, slt_en, sltu_en, xor_en, srl_en, or_en, and_en`  out  1 each  one-hot operation strobes.
- `op_a`  out  32  operand A (rs1_data).
- `op_b`  out  32  operand B (rs2_data or sign-extended immediate).
- `rd_addr`  out  5  destination register, `instr[11:7]`.
- `illegal`  out  1  held entry is an unsupported encoding.
- `illegal_count`  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode fields: opcode `instr[6:0]`, funct3 `instr[14:12]`, funct7 `instr[31:25]`.
- OP (0110011), funct7 = 0000000: funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
- OP with funct7 = 0100000: funct3 000 sub, 101 sra. All other OP encodings are illegal.
- OP-IMM (0010011): 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and, with `op_b` = sign-extended `instr[31:20]`.
- OP-IMM shifts: 001 with `instr[31:25]`=0 → sll; 101 with `instr[31:25]`=0 → srl; 101 with `instr[31:25]`=0100000 → sra. Any other upper bits are illegal.
- Any other opcode is illegal.
- An illegal entry sets all ten enables to 0 and `illegal`=1. It still passes through the handshake, and operands and `rd_addr` are still captured.
- At most one enable is high at any time. All enables are 0 whenever `out_valid`=0.
- Acceptance: `in_ready = !out_valid || out_ready` (combinational). Accept = `in_valid && in_ready && !flush`. On accept, the output register loads the decode and `out_valid` is set to 1.
- Drain: `out_valid && out_ready` with no new accept clears `out_valid` and zeroes the enables and `illegal`.
- `flush` has priority over accept and drain. In a flush cycle `out_valid` becomes 0, enables and `illegal` become 0, the input is not accepted, and the counter does not change.
- `illegal_count` increments on each accepted illegal instruction. It saturates at all-ones and does not wrap.
- Holding: while `out_valid && !out_ready`, all outputs remain stable.

## Timing
- Reset (async, `rst_n`=0): `out_valid`=0, all enables 0, `illegal`=0, `op_a`=`op_b`=0, `rd_addr`=0, `illegal_count`=0. `in_ready`=1 while in reset.
- Latency is 1 cycle: an instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput is 1 per cycle while `out_ready`=1. Simultaneous drain and accept in the same cycle replaces the entry with no bubble.
- Reset asserted mid-hold drops the entry immediately, without waiting for a clock edge.
- There is no internal state beyond the output register and the counter. The stage has no FSM other than the valid bit: EMPTY→FULL on accept, FULL→EMPTY on drain without accept, or on flush.

## Test plan
- Reset then `instr`=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 → next cycle `add_en`=1 only, op_a=5, op_b=7, rd_addr=3, illegal=0.
- `instr`=0x402081B3 (sub) then 0x4030D293 (srai x5,x1,3) back-to-back with out_ready=1 → consecutive cycles show `sub_en`, then `sra_en` with op_b=0x00000403 and rd_addr=5; no bubble.
- `instr`=0xFFF00293 (addi x5,x0,-1), out_ready=0 for 3 cycles → `add_en`=1, op_b=0xFFFFFFFF held stable, `in_ready`=0, second offered instruction not accepted until out_ready=1.
- `instr`=0x402091B3 (funct7=0100000, funct3=001) and 0x0000006F (JAL) → all enables 0, illegal=1, `illegal_count` 0→1→2. Preloading 0xFFFF then one more illegal instruction leaves the count at 0xFFFF.
- Held entry, then `flush`=1 together with `in_valid`=1 → out_valid=0 next cycle, input not consumed, counter unchanged.
- Held entry, `rst_n` pulsed low between clock edges → out_valid and enables drop to 0 immediately, and all outputs read reset values.
